// File: rtl/md_pkg.sv
// Shared multiply/divide definitions: op-class encoding, issue FSM states, op helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package md_pkg;

    // MDU op class. The decoder and the MDU wrapper use the same encoding.
    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MADD  = 4'd5,
        MD_MFHI  = 4'd6,
        MD_MFLO  = 4'd7,
        MD_MTHI  = 4'd8,
        MD_MTLO  = 4'd9
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    // Ops that occupy the MDU for several cycles. Codes outside the
    // encoding fall to default and behave like NONE.
    function automatic logic is_long_op(input logic [3:0] op);
        case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MADD: return 1'b1;
            default:                                     return 1'b0;
        endcase
    endfunction

    // Selects the divide latency rather than the multiply latency.
    function automatic logic is_div_op(input logic [3:0] op);
        case (op)
            MD_DIV, MD_DIVU: return 1'b1;
            default:         return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mdu_issue_ctrl_sat_counter.sv
// Saturating up-counter with enable, used for performance counting.
// Latency: count visible the cycle after the enabled edge.
// Backpressure: none; holds at all-ones once saturated.
//
// Ports: clk, reset (sync, active-high), en_i (count this cycle),
//        cnt_o (current count, W bits).
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/mdu_issue_ctrl.sv
// E-stage issue and D-stage interlock control for the multiply/divide unit.
// Latency: mdu_start/md_busy/stall_d are combinational in the issue cycle; busy then lasts LAT cycles.
// Backpressure: stall_d holds any MDU-using instruction in D while the MDU is starting or busy.
//
// Ports: clk, reset (sync, active-high); e_valid/e_md_op/e_flush describe the
//        E-stage instruction; d_md_use flags an MDU user in D; mdu_busy is the
//        MDU's own busy. Outputs: mdu_start, md_busy, stall_d, sticky err_sync
//        and err_proto, saturating counters stall_cycles and md_ops.
module mdu_issue_ctrl
    import md_pkg::*;
#(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             e_valid,
    input  logic [3:0]       e_md_op,
    input  logic             e_flush,
    input  logic             d_md_use,
    input  logic             mdu_busy,
    output logic             mdu_start,
    output logic             md_busy,
    output logic             stall_d,
    output logic             err_sync,
    output logic             err_proto,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] md_ops
);

    localparam logic [3:0] MUL_CNT = 4'(MUL_LAT);
    localparam logic [3:0] DIV_CNT = 4'(DIV_LAT);

    md_state_e  state_q;
    logic [3:0] cnt_q;
    logic       err_sync_q;
    logic       err_proto_q;

    logic long_op;
    logic run;
    logic fire;

    assign long_op = e_valid & is_long_op(e_md_op);
    assign run     = (state_q == ST_RUN);
    // Start is combinational so the MDU samples it on the same edge that
    // moves us into RUN; the two busy windows then line up exactly.
    assign fire    = ~run & long_op & ~e_flush;

    assign mdu_start = fire;
    assign md_busy   = fire | run;
    assign stall_d   = d_md_use & md_busy;
    assign err_sync  = err_sync_q;
    assign err_proto = err_proto_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            err_sync_q  <= 1'b0;
            err_proto_q <= 1'b0;
        end else begin
            if (mdu_busy != run) begin
                err_sync_q <= 1'b1;
            end
            if (state_q == ST_IDLE) begin
                if (fire) begin
                    cnt_q   <= is_div_op(e_md_op) ? DIV_CNT : MUL_CNT;
                    state_q <= ST_RUN;
                end
            end else begin
                // The MDU cannot abort, so flush is ignored here. A long op
                // reaching E now means the D-stage interlock was bypassed.
                if (long_op) begin
                    err_proto_q <= 1'b1;
                end
                if (cnt_q == 4'd1) begin
                    state_q <= ST_IDLE;
                    cnt_q   <= 4'd0;
                end else begin
                    cnt_q <= cnt_q - 4'd1;
                end
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .en_i  (stall_d),
        .cnt_o (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_ops_cnt (
        .clk   (clk),
        .reset (reset),
        .en_i  (fire),
        .cnt_o (md_ops)
    );

endmodule

// File: doc/mdu_issue_ctrl.md
Name: mdu_issue_ctrl

Overview:
- E-stage issue and interlock controller for the multiply/divide unit.
- Decides when an E-stage mult/div/madd fires the MDU `start` pulse.
- Tracks MDU occupancy with its own latency counter.
- Raises the D-stage stall whenever an instruction in D needs HI/LO (or a new MDU op) while the MDU is starting or busy.
- Sits between the decode/hazard logic and the MDU. Also keeps a sticky consistency check against the MDU's own `busy` and two performance counters.

Parameters:
- MUL_LAT, 5, MDU busy cycles after a MULT/MULTU/MADD start (1..15)
- DIV_LAT, 10, MDU busy cycles after a DIV/DIVU start (1..15)
- CNT_W, 32, width of the performance counters

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- e_valid  in  1  E stage holds a real (non-bubble) instruction
- e_md_op  in  4  MDU op class of the E-stage instruction (package encoding)
- e_flush  in  1  E-stage instruction is being killed this cycle
- d_md_use  in  1  D-stage instruction is any MDU op (MULT..MTLO, MFHI, MFLO)
- mdu_busy  in  1  busy output of the MDU
- mdu_start  out  1  start pulse to the MDU
- md_busy  out  1  controller's view of MDU occupancy, including the start cycle
- stall_d  out  1  freeze PC/D, insert bubble into E
- err_sync  out  1  sticky: mdu_busy disagreed with the internal state
- err_proto  out  1  sticky: long op presented in E while RUN
- stall_cycles  out  CNT_W  saturating count of cycles with stall_d=1
- md_ops  out  CNT_W  saturating count of issued long ops

Behaviour:
- Reset values: state=IDLE, cnt=0, both counters 0, err_sync=0, err_proto=0.
- Outputs after reset: mdu_start=0, md_busy=0, stall_d=0 (given quiet inputs).
- Long op: e_md_op is MULT, MULTU, MADD, DIV or DIVU.
  - LAT(op) = MUL_LAT for MULT/MULTU/MADD.
  - LAT(op) = DIV_LAT for DIV/DIVU.
- FSM has two states, IDLE and RUN; cnt is 4 bits.
- In IDLE:
  - fire = e_valid & long op & !e_flush.
  - mdu_start = fire, combinational, so the MDU samples it at the same edge.
  - If fire: cnt <= LAT(op), state <= RUN, md_ops++ (saturating).
- In RUN:
  - mdu_start=0.
  - cnt decrements each cycle.
  - When cnt==1, next state is IDLE with cnt=0.
  - RUN therefore lasts exactly LAT cycles, aligned with the MDU busy window that follows the start edge.
- md_busy = fire | (state==RUN).
- stall_d = d_md_use & md_busy.
  - MFHI/MFLO/MTHI/MTLO and any new long op are held in D until md_busy=0.
  - First release is the cycle after RUN's last cycle.
- Short ops (MFHI/MFLO/MTHI/MTLO, NONE) in E never fire and never change state.
- e_flush:
  - Suppresses fire in IDLE.
  - In RUN it has no effect, because the MDU cannot abort. Counting and stalling continue.
- Long op with e_valid in E while RUN:
  - Must not occur, because stall_d prevents it.
  - If it occurs: set err_proto, no start, state unaffected.
- Consistency check:
  - Each cycle, compare mdu_busy with (state==RUN).
  - Any mismatch sets err_sync. It clears only on reset.
- stall_cycles increments on every cycle with stall_d=1 and saturates at all-ones.
- Reset asserted mid-RUN: next cycle is IDLE, cnt=0, stall_d=0, counters and errors cleared.
- e_md_op values outside the defined encoding are treated as NONE.

Decomposition:
- Shared package `md_pkg` holds:
  - the 4-bit MD op encoding: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MADD=5, MFHI=6, MFLO=7, MTHI=8, MTLO=9
  - the state enum: IDLE, RUN
  - the helper function is_long_op
- The decoder and the MDU wrapper use the same encoding.
- One sub-module, `sat_counter` (CNT_W-bit, enable, synchronous reset), instantiated twice for the performance counters.

Test Plan:
- MULT issue: IDLE, e_valid=1, op=MULT, d_md_use=1 on the following cycles.
  - Start cycle: mdu_start=1 for 1 cycle, md_busy=1.
  - RUN: 5 further cycles with stall_d=1.
  - 7th cycle from start: stall_d=0, md_ops=1, stall_cycles=6.
- DIV then MFLO: op=DIV, then MFLO held in D.
  - stall_d is high for 11 cycles (start cycle plus 10).
  - Release exactly when mdu_busy falls; err_sync stays 0 with a model MDU.
- Flush at issue: op=DIVU, e_valid=1, e_flush=1.
  - mdu_start=0, state stays IDLE, md_ops=0.
  - Repeat with e_flush asserted on the 3rd RUN cycle: RUN still lasts 10 cycles.
- Protocol/sync errors:
  - Force op=MULT, e_valid=1 while RUN: err_proto=1, no second start, RUN length unchanged.
  - Tie mdu_busy=1 while IDLE: err_sync=1 and remains 1.
- Reset mid-op: reset asserted on cycle 4 of DIV RUN.
  - Next cycle: md_busy=0, stall_d=0, counters=0, errors=0.
  - A new MULT is then accepted normally.
- Saturation: preload stall_cycles to 0xFFFFFFFE via long stall.
  - Use a short CNT_W=4 build: counter reaches 15 and holds at 15.
